gate_plant: RTL and testbench
=============================

Name: gate_plant

Overview:
- Behavioural/synthesizable model of the garage gate mechanism: motor, position travel and light-barrier sensor.
- Consumes the open/close drive commands that the gate controller emits on its green (opening) and red (closing) lamps.
- Produces the motor-running flag and obstacle sensor that the controller reads on its motor and sensor switches. This closes the loop on the board or in simulation.
- Shows the mechanism state on a 7-segment digit.

Parameters:
TRAVEL, 100, number of position steps between fully closed (0) and fully open (TRAVEL); must be 2..127
STEP_DIV, 270000, CLOCK_27 cycles per position step (10 ms at 27 MHz); must be >= 2

Ports:
CLOCK_27  input  1  27 MHz board clock; all logic on rising edge
RESET  input  1  synchronous, active-high reset
OPEN_CMD  input  1  drive gate toward open (from controller opening lamp)
CLOSE_CMD  input  1  drive gate toward closed (from controller closing lamp)
OBSTACLE_REQ  input  1  obstacle present in the gate path (board switch / bench)
MOTOR  output  1  motor running; 1 only in OPENING or CLOSING
SENSOR  output  1  light-barrier output; 1 = obstacle detected
POSITION  output  7  current gate position, 0..TRAVEL
FULLY_OPEN  output  1  POSITION == TRAVEL
FULLY_CLOSED  output  1  POSITION == 0
HEX0  output  7  active-low segments {g..a}: state display

Behaviour:
- States: CLOSED, OPENING, OPEN, CLOSING, STALLED. All outputs registered (Moore); the state change and its outputs appear one cycle after the command is sampled.
- Reset (RESET=1 at a clock edge, from any state, including mid-travel):
  - state CLOSED, POSITION 0, prescaler 0.
  - MOTOR 0, SENSOR 0, FULLY_CLOSED 1, FULLY_OPEN 0, HEX0 7'b0001110 ("F").
  - RESET has priority over all inputs.
- Command decode: cmd = OPEN if OPEN_CMD & ~CLOSE_CMD; CLOSE if CLOSE_CMD & ~OPEN_CMD; otherwise NONE. Both high counts as NONE.
- Transitions:
  - CLOSED: OPEN -> OPENING; else stay.
  - OPEN: CLOSE -> CLOSING; else stay.
  - OPENING:
    - CLOSE -> CLOSING (direct reversal).
    - NONE -> STALLED.
    - step tick and POSITION == TRAVEL-1 -> OPEN.
  - CLOSING:
    - OPEN -> OPENING (direct reversal).
    - NONE -> STALLED.
    - step tick and POSITION == 1 -> CLOSED.
  - STALLED: OPEN -> OPENING; CLOSE -> CLOSING; else stay.
  - A command change wins over a coincident step tick: no position step is taken on that cycle.
- Prescaler:
  - Counts 0..STEP_DIV-1 only in OPENING/CLOSING; step tick when count == STEP_DIV-1, then the count wraps to 0.
  - Cleared on every entry to OPENING or CLOSING, including reversal. The first step therefore lands exactly STEP_DIV cycles after MOTOR rises.
  - Held at 0 in the other states.
- Position:
  - +1 per tick in OPENING, -1 per tick in CLOSING.
  - Saturates at 0 and TRAVEL; never wraps. POSITION changes only on a tick.
  - FULLY_OPEN/FULLY_CLOSED update in the same cycle as POSITION.
- MOTOR: 1 exactly while state is OPENING or CLOSING.
- SENSOR:
  - Registered OBSTACLE_REQ (1-cycle latency), gated to 0 while state is CLOSED (closed gate blocks the barrier).
  - Does not itself change state or motion; the controller reacts.
- HEX0 (active-low):
  - CLOSED 7'b0001110 "F"
  - OPEN 7'b0001000 "A"
  - OPENING/CLOSING 7'b1000000 "0"
  - STALLED 7'b0111111 "-"
- Inputs are assumed synchronous to CLOCK_27. Debouncing and synchronisation are outside this block.

Test Plan:
- Directed tests use TRAVEL=5, STEP_DIV=4.
- Reset/open travel: RESET 1 cycle, OPEN_CMD held 1 -> MOTOR=1 one cycle after sample; POSITION 1,2,3,4,5 at 4-cycle spacing; on reaching 5, state OPEN, MOTOR=0, FULLY_OPEN=1, HEX0=7'b0001000.
- Close and end stop: from OPEN, CLOSE_CMD held -> POSITION 4..0 at 4-cycle spacing, then CLOSED, FULLY_CLOSED=1, HEX0=7'b0001110. Further CLOSE_CMD for 20 cycles -> POSITION stays 0, MOTOR=0.
- Reversal: closing at POSITION 3 with prescaler at 2, switch to OPEN_CMD -> no step that cycle, state OPENING, prescaler 0. POSITION becomes 4 exactly 4 cycles after MOTOR is seen in OPENING.
- Stall and both-high: OPENING at POSITION 2, drop OPEN_CMD -> STALLED, MOTOR=0, HEX0=7'b0111111, POSITION 2 held for 10 cycles. Then assert OPEN_CMD and CLOSE_CMD together -> remains STALLED.
- Sensor: OBSTACLE_REQ=1 while CLOSING at POSITION 3 -> SENSOR=1 one cycle later, motion continues. In CLOSED with OBSTACLE_REQ=1 -> SENSOR=0.
- Reset mid-operation: RESET asserted during OPENING at POSITION 3 -> next cycle CLOSED, POSITION 0, MOTOR 0, SENSOR 0, prescaler restarts cleanly on the next OPEN_CMD.

Source files
------------

// File: rtl/gate_plant_if.sv
// Command/status bundle between the gate controller and the gate plant model.
// No latency of its own; it only groups the wires.
// No backpressure: commands are levels, sampled every cycle by the plant.
interface gate_plant_if;
    logic       OPEN_CMD;
    logic       CLOSE_CMD;
    logic       OBSTACLE_REQ;
    logic       MOTOR;
    logic       SENSOR;
    logic [6:0] POSITION;
    logic       FULLY_OPEN;
    logic       FULLY_CLOSED;
    logic [6:0] HEX0;

    // Controller / bench side: drives commands, observes the mechanism
    modport master (
        output OPEN_CMD, CLOSE_CMD, OBSTACLE_REQ,
        input  MOTOR, SENSOR, POSITION, FULLY_OPEN, FULLY_CLOSED, HEX0
    );

    // Plant side: consumes commands, reports the mechanism
    modport slave (
        input  OPEN_CMD, CLOSE_CMD, OBSTACLE_REQ,
        output MOTOR, SENSOR, POSITION, FULLY_OPEN, FULLY_CLOSED, HEX0
    );
endinterface

// File: rtl/gate_plant.sv
// Garage gate mechanism model: motor, position travel, light barrier, state digit.
// Latency: all outputs registered; state/outputs follow a sampled command by 1 cycle.
// No backpressure: open/close/obstacle are level inputs sampled every clock.
module gate_plant #(
    parameter int TRAVEL   = 100,
    parameter int STEP_DIV = 270000
) (
    input  logic         CLOCK_27,
    input  logic         RESET,
    gate_plant_if.slave  plant
);

    localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [6:0]    TRAV_MAX  = 7'(TRAVEL);

    localparam logic [6:0] HEX_F    = 7'b0001110;
    localparam logic [6:0] HEX_A    = 7'b0001000;
    localparam logic [6:0] HEX_0    = 7'b1000000;
    localparam logic [6:0] HEX_DASH = 7'b0111111;

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_STALLED
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    pos_q, pos_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          motor_q, motor_d;
    logic          sensor_q, sensor_d;
    logic          fo_q, fo_d;
    logic          fc_q, fc_d;
    logic [6:0]    hex_q, hex_d;

    logic cmd_open;
    logic cmd_close;
    logic tick;

    // Next state, position and prescaler; a command change pre-empts a coincident step
    always_comb begin
        cmd_open  = plant.OPEN_CMD & ~plant.CLOSE_CMD;
        cmd_close = plant.CLOSE_CMD & ~plant.OPEN_CMD;
        tick      = (presc_q == PRESC_MAX);
        state_d   = state_q;
        pos_d     = pos_q;
        presc_d   = '0;

        case (state_q)
            ST_CLOSED: begin
                if (cmd_open) state_d = ST_OPENING;
            end
            ST_OPEN: begin
                if (cmd_close) state_d = ST_CLOSING;
            end
            ST_OPENING: begin
                if (cmd_close) begin
                    state_d = ST_CLOSING;
                end else if (!cmd_open) begin
                    state_d = ST_STALLED;
                end else if (tick) begin
                    if (pos_q != TRAV_MAX) pos_d = pos_q + 7'd1;
                    if (pos_q == TRAV_MAX - 7'd1) state_d = ST_OPEN;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_CLOSING: begin
                if (cmd_open) begin
                    state_d = ST_OPENING;
                end else if (!cmd_close) begin
                    state_d = ST_STALLED;
                end else if (tick) begin
                    if (pos_q != 7'd0) pos_d = pos_q - 7'd1;
                    if (pos_q == 7'd1) state_d = ST_CLOSED;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_STALLED: begin
                if (cmd_open)       state_d = ST_OPENING;
                else if (cmd_close) state_d = ST_CLOSING;
            end
            default: begin
                state_d = ST_CLOSED;
            end
        endcase
    end

    // Moore outputs computed from the next state so they register alongside it
    always_comb begin
        motor_d  = (state_d == ST_OPENING) || (state_d == ST_CLOSING);
        sensor_d = plant.OBSTACLE_REQ & (state_d != ST_CLOSED);
        fo_d     = (pos_d == TRAV_MAX);
        fc_d     = (pos_d == 7'd0);
        case (state_d)
            ST_CLOSED: hex_d = HEX_F;
            ST_OPEN:   hex_d = HEX_A;
            ST_STALLED: hex_d = HEX_DASH;
            default:   hex_d = HEX_0;
        endcase
    end

    // State and output registers with synchronous reset to a closed, idle gate
    always_ff @(posedge CLOCK_27) begin
        if (RESET) begin
            state_q  <= ST_CLOSED;
            pos_q    <= 7'd0;
            presc_q  <= '0;
            motor_q  <= 1'b0;
            sensor_q <= 1'b0;
            fo_q     <= 1'b0;
            fc_q     <= 1'b1;
            hex_q    <= HEX_F;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            presc_q  <= presc_d;
            motor_q  <= motor_d;
            sensor_q <= sensor_d;
            fo_q     <= fo_d;
            fc_q     <= fc_d;
            hex_q    <= hex_d;
        end
    end

    assign plant.MOTOR        = motor_q;
    assign plant.SENSOR       = sensor_q;
    assign plant.POSITION     = pos_q;
    assign plant.FULLY_OPEN   = fo_q;
    assign plant.FULLY_CLOSED = fc_q;
    assign plant.HEX0         = hex_q;

endmodule

// File: tb/tb_gate_plant.sv
// Directed scoreboard bench for gate_plant with TRAVEL=5, STEP_DIV=4.
// Driver pushes the expected output vector for each checked cycle;
// a negedge monitor pops and compares independently.
module tb_gate_plant;

    localparam logic [6:0] HF = 7'b0001110;
    localparam logic [6:0] HA = 7'b0001000;
    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] HS = 7'b0111111;

    typedef struct {
        int          cyc;
        logic [17:0] v;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    gate_plant_if gif();

    gate_plant #(.TRAVEL(5), .STEP_DIV(4)) dut (
        .CLOCK_27 (clk),
        .RESET    (rst),
        .plant    (gif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected vector for the current cycle: {motor, sensor, pos, fully_open, fully_closed, hex}
    task automatic expect_now(input string name, input logic m, input logic s,
                              input logic [6:0] p, input logic [6:0] h);
        exp_t e;
        e.cyc  = cyc;
        e.v    = {m, s, p, (p == 7'd5), (p == 7'd0), h};
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due in this cycle against the DUT
    always @(negedge clk) begin
        exp_t        e;
        logic [17:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = {gif.MOTOR, gif.SENSOR, gif.POSITION, gif.FULLY_OPEN, gif.FULLY_CLOSED, gif.HEX0};
            total++;
            if (e.cyc != cyc || act !== e.v) begin
                bad++;
                $display("FAIL %s cyc=%0d got m/s/pos/fo/fc/hex=%b/%b/%0d/%b/%b/%b want %b/%b/%0d/%b/%b/%b",
                         e.name, cyc, act[17], act[16], act[15:9], act[8], act[7], act[6:0],
                         e.v[17], e.v[16], e.v[15:9], e.v[8], e.v[7], e.v[6:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        gif.OPEN_CMD     = 1'b0;
        gif.CLOSE_CMD    = 1'b0;
        gif.OBSTACLE_REQ = 1'b0;

        // Reset state
        step();
        expect_now("reset", 0, 0, 7'd0, HF);
        rst = 1'b0;

        // Open travel: step every 4 cycles after motor start
        gif.OPEN_CMD = 1'b1;
        step();
        expect_now("open_start", 1, 0, 7'd0, H0);
        for (int k = 1; k <= 5; k++) begin
            repeat (3) step();
            expect_now("open_pre", 1, 0, 7'(k - 1), H0);
            step();
            if (k == 5) expect_now("open_end", 0, 0, 7'd5, HA);
            else        expect_now("open_step", 1, 0, 7'(k), H0);
        end

        // Close travel down to the end stop
        gif.OPEN_CMD  = 1'b0;
        gif.CLOSE_CMD = 1'b1;
        step();
        expect_now("close_start", 1, 0, 7'd5, H0);
        for (int k = 1; k <= 5; k++) begin
            repeat (3) step();
            expect_now("close_pre", 1, 0, 7'(6 - k), H0);
            step();
            if (k == 5) expect_now("closed", 0, 0, 7'd0, HF);
            else        expect_now("close_step", 1, 0, 7'(5 - k), H0);
        end

        // End stop holds; barrier blocked while closed
        gif.OBSTACLE_REQ = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            expect_now("endstop", 0, 0, 7'd0, HF);
        end
        gif.OBSTACLE_REQ = 1'b0;

        // Reopen fully
        gif.CLOSE_CMD = 1'b0;
        gif.OPEN_CMD  = 1'b1;
        step();
        expect_now("reopen_start", 1, 0, 7'd0, H0);
        repeat (20) step();
        expect_now("reopen_end", 0, 0, 7'd5, HA);

        // Close to position 3, then obstacle while moving
        gif.OPEN_CMD  = 1'b0;
        gif.CLOSE_CMD = 1'b1;
        step();
        expect_now("close2_start", 1, 0, 7'd5, H0);
        repeat (8) step();
        expect_now("close2_pos3", 1, 0, 7'd3, H0);
        gif.OBSTACLE_REQ = 1'b1;
        step();
        expect_now("sensor_on", 1, 1, 7'd3, H0);
        step();
        expect_now("sensor_move", 1, 1, 7'd3, H0);

        // Reversal with prescaler at 2: restart count, step 4 cycles later
        gif.CLOSE_CMD = 1'b0;
        gif.OPEN_CMD  = 1'b1;
        step();
        expect_now("reverse", 1, 1, 7'd3, H0);
        repeat (3) step();
        expect_now("rev_pre", 1, 1, 7'd3, H0);
        step();
        expect_now("rev_step", 1, 1, 7'd4, H0);

        // Reversal on the tick cycle: command wins, no step taken
        gif.OBSTACLE_REQ = 1'b0;
        repeat (3) step();
        expect_now("tick_pre", 1, 0, 7'd4, H0);
        gif.OPEN_CMD  = 1'b0;
        gif.CLOSE_CMD = 1'b1;
        step();
        expect_now("coincide", 1, 0, 7'd4, H0);
        repeat (8) step();
        expect_now("to_two", 1, 0, 7'd2, H0);

        // Stall while opening at position 2, then both commands high
        gif.CLOSE_CMD = 1'b0;
        gif.OPEN_CMD  = 1'b1;
        step();
        expect_now("reopen2", 1, 0, 7'd2, H0);
        gif.OPEN_CMD = 1'b0;
        step();
        expect_now("stall", 0, 0, 7'd2, HS);
        for (int i = 0; i < 10; i++) begin
            step();
            expect_now("stall_hold", 0, 0, 7'd2, HS);
        end
        gif.OPEN_CMD  = 1'b1;
        gif.CLOSE_CMD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_now("both_high", 0, 0, 7'd2, HS);
        end

        // Resume, then reset mid-travel with OPEN_CMD still asserted
        gif.CLOSE_CMD = 1'b0;
        step();
        expect_now("resume", 1, 0, 7'd2, H0);
        repeat (4) step();
        expect_now("mid_pos3", 1, 0, 7'd3, H0);
        gif.OBSTACLE_REQ = 1'b1;
        repeat (2) step();
        expect_now("mid_sensor", 1, 1, 7'd3, H0);
        rst = 1'b1;
        step();
        expect_now("mid_reset", 0, 0, 7'd0, HF);
        rst = 1'b0;
        gif.OBSTACLE_REQ = 1'b0;
        step();
        expect_now("restart", 1, 0, 7'd0, H0);
        repeat (3) step();
        expect_now("restart_pre", 1, 0, 7'd0, H0);
        step();
        expect_now("restart_step", 1, 0, 7'd1, H0);

        repeat (2) step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
